// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder built around one _full_adder cell.
// One operand bit is added per clock; the carry is registered and fed back
// into the cell's Cin.  A start/busy/done handshake frames each addition.
// Optional: define BIT_SERIAL_ADDER_OVF_EN to add a registered signed-overflow
// output (ovf), evaluated on the final bit.

// Gate-level full adder cell: the only arithmetic element of the serial adder.
module _full_adder (
   input  logic a,
   input  logic b,
   input  logic Cin,
   output logic S,
   output logic Cout
);
   logic p;

   assign p    = a ^ b;
   assign S    = p ^ Cin;
   assign Cout = (a & b) | (p & Cin);
endmodule

module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Counter is at least one bit wide so WIDTH=1 still elaborates cleanly.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             cout_bit;
   logic             last;

   _full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .Cin  (carry),
      .S    (s_bit),
      .Cout (cout_bit)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB result.
   // Written without a part-select so the same expression covers WIDTH=1.
   assign sum_next = (sum_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
   assign last     = (cnt == LAST);

   // Control FSM, serial datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         S      <= '0;
         Cout   <= 1'b0;
         // NOTE: the datapath registers are reset too, so an aborted run
         // leaves no stale operand, carry or count behind.
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // NOTE: non-blocking assignments so every register here
                  // samples pre-edge values regardless of statement order.
                  a_sh   <= a;
                  b_sh   <= b;
                  carry  <= Cin;
                  cnt    <= '0;
                  sum_sh <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sum_sh <= sum_next;
               carry  <= cout_bit;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  S     <= sum_next;
                  Cout  <= cout_bit;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                  // carry currently holds the carry into the MSB position.
                  ovf   <= carry ^ cout_bit;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Testbench for bit_serial_adder: WIDTH=8 instance driven from a vector table,
// hand-written handshake/reset sequences and random operands against a plain
// arithmetic model; a WIDTH=1 instance is checked over all input combinations.
module tb_bit_serial_adder;

   logic       clk;
   logic       rst_n;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       cin8;
   logic       busy8;
   logic       done8;
   logic [7:0] s8;
   logic       cout8;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       busy1;
   logic       done1;
   logic [0:0] s1;
   logic       cout1;

`ifdef BIT_SERIAL_ADDER_OVF_EN
   logic       ovf8;
   logic       ovf1;
`endif

   int errors = 0;
   int checks = 0;

   bit_serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .Cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .S     (s8),
      .Cout  (cout8)
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf8)
`endif
   );

   bit_serial_adder #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .Cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .S     (s1),
      .Cout  (cout1)
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       cout;
      logic       ovf;
      string      name;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: unsigned {Cout,S} = a + b + Cin.
   function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y, input logic c);
      return 9'(x) + 9'(y) + 9'(c);
   endfunction

   // Reference: signed two's-complement result outside the 8-bit range.
   function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
      int t;
      t = $signed(x) + $signed(y) + $signed({1'b0, c});
      return (t > 127) || (t < -128);
   endfunction

   // One complete WIDTH=8 operation with latency, busy, hold and result checks.
   task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input string name);
      int         n;
      int         busy_n;
      logic [7:0] ps;
      logic       pc;
      logic       held;
      ps     = s8;
      pc     = cout8;
      held   = 1'b1;
      a8     = x;
      b8     = y;
      cin8   = c;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      n      = 0;
      busy_n = 0;
      while (!done8 && n < 40) begin
         if (busy8) busy_n++;
         if (s8 !== ps || cout8 !== pc) held = 1'b0;
         tick();
         n++;
      end
      check({name, " latency"}, n, 8);
      check({name, " busy cycles"}, busy_n, 8);
      check({name, " prev result held"}, held, 1);
      check({name, " S"}, s8, es);
      check({name, " Cout"}, cout8, ec);
`ifdef BIT_SERIAL_ADDER_OVF_EN
      check({name, " ovf"}, ovf8, eo);
`else
      if (eo === 1'bx) $display("note: ovf expectation undefined for %s", name);
`endif
      tick();
      check({name, " done drops"}, done8, 0);
      check({name, " busy after done"}, busy8, 0);
   endtask

   initial begin
      logic [8:0] exp9;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [2:0] v;
      int         n;
      int         dones;

      vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "basic"};
      vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "carry chain"};
      vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero back-to-back"};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "pos overflow"};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "neg overflow"};
      vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "no overflow"};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "all ones"};
      vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "complement plus one"};

      // Reset held with start and all-ones operands: nothing may start.
      rst_n  = 1'b0;
      start8 = 1'b1;
      a8     = 8'hFF;
      b8     = 8'hFF;
      cin8   = 1'b1;
      start1 = 1'b0;
      a1     = 1'b0;
      b1     = 1'b0;
      cin1   = 1'b0;
      #2;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset busy", busy8, 0);
         check("reset done", done8, 0);
         check("reset S", s8, 0);
         check("reset Cout", cout8, 0);
      end
      start8 = 1'b0;
      rst_n  = 1'b1;
      tick();
      check("idle after reset busy", busy8, 0);

      // Table-driven vectors, back-to-back: each starts in the first IDLE cycle.
      foreach (vecs[i])
         op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].cout, vecs[i].ovf, vecs[i].name);

      // start held through RUN with operands changing after acceptance.
      a8     = 8'h11;
      b8     = 8'h22;
      cin8   = 1'b0;
      start8 = 1'b1;
      tick();
      a8     = 8'h77;
      b8     = 8'h77;
      n      = 0;
      dones  = 0;
      while (!done8 && n < 40) begin
         tick();
         n++;
      end
      if (done8) dones++;
      check("ignored start latency", n, 8);
      check("ignored start S", s8, 8'h33);
      check("ignored start Cout", cout8, 0);
      tick();
      check("start ignored in DONE", busy8, 0);
      check("single done pulse", done8, 0);
      tick();
      check("start accepted from IDLE", busy8, 1);
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 40) begin
         tick();
         n++;
      end
      if (done8) dones++;
      check("second op latency", n, 8);
      check("second op S", s8, 8'h EE);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done8) dones++;
      end
      check("done pulses per accepted start", dones, 2);

      // Reset after four RUN cycles aborts the operation.
      a8     = 8'hF0;
      b8     = 8'h0F;
      cin8   = 1'b0;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mid-run busy before reset", busy8, 1);
      rst_n = 1'b0;
      #1;
      check("abort S cleared", s8, 0);
      check("abort Cout cleared", cout8, 0);
      check("abort busy cleared", busy8, 0);
      check("abort done low", done8, 0);
      tick();
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) dones++;
      end
      check("no done after abort", dones, 0);
      op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after abort");

      // Random operands against the arithmetic model.
      for (int i = 0; i < 30; i++) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rc   = 1'($urandom);
         exp9 = ref_sum(ra, rb, rc);
         op8(ra, rb, rc, exp9[7:0], exp9[8], ref_ovf(ra, rb, rc), "random");
      end

      // WIDTH=1: exhaustive, done exactly one cycle after acceptance.
      for (int i = 0; i < 8; i++) begin
         v      = 3'(i);
         a1     = v[0];
         b1     = v[1];
         cin1   = v[2];
         start1 = 1'b1;
         tick();
         start1 = 1'b0;
         check("w1 busy", busy1, 1);
         check("w1 done early", done1, 0);
         tick();
         check("w1 done", done1, 1);
         check("w1 sum", {cout1, s1}, 2'(v[0]) + 2'(v[1]) + 2'(v[2]));
         tick();
         check("w1 done drops", done1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
